// File: rtl/instruction_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// Holds the PC, issues word fetches over a req/ready handshake, honours the
// hazard-unit stall and the EX-stage redirect, and parks one response in a
// skid register when it arrives while IF/ID is stalled.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IF_ID_Write,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [6:0]  instr_OP,
   output logic [4:0]  Ra,
   output logic [4:0]  Rb,
   output logic [4:0]  Rd,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        instr_valid
);

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] skid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic        ifid_valid;
   logic [31:0] pc_next_seq;

   // Low target bits are forced to zero; fetches are always word aligned.
   logic unused_target_bits;
   assign unused_target_bits = ^branch_target[1:0];

   assign pc_next_seq = pc + 32'd4;

   // PC, fetch FSM, skid register and IF/ID register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= {RESET_PC[31:2], 2'b00};
         state      <= FETCH;
         skid       <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_pc    <= '0;
         ifid_valid <= 1'b0;
      end else if (branch_taken) begin
         // Redirect wins over stall; any in-flight or parked word is discarded.
         pc         <= {branch_target[31:2], 2'b00};
         state      <= FETCH;
         skid       <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
      end else begin
         unique case (state)
            FETCH: begin
               if (imem_ready) begin
                  if (IF_ID_Write) begin
                     ifid_instr <= imem_rdata;
                     ifid_pc    <= pc;
                     ifid_valid <= 1'b1;
                     pc         <= pc_next_seq;
                  end else begin
                     skid  <= imem_rdata;
                     state <= HOLD;
                  end
               end else if (IF_ID_Write) begin
                  ifid_instr <= NOP_INSTR;
                  ifid_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (IF_ID_Write) begin
                  ifid_instr <= skid;
                  ifid_pc    <= pc;
                  ifid_valid <= 1'b1;
                  pc         <= pc_next_seq;
                  state      <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   assign imem_req    = (state == FETCH) && !rst;
   assign imem_addr   = pc;

   assign instr       = ifid_instr;
   assign instr_OP    = ifid_instr[6:0];
   assign Rd          = ifid_instr[11:7];
   assign Ra          = ifid_instr[19:15];
   assign Rb          = ifid_instr[24:20];
   assign pc_out      = ifid_pc;
   assign pc_plus4    = ifid_pc + 32'd4;
   assign instr_valid = ifid_valid;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage plus IF/ID pipeline register; feeds Instruction_Decode with the registered instruction, its PC and pre-sliced register addresses.
- Holds the PC and issues word fetches to instruction memory over a req/ready handshake.
- Obeys the hazard unit's IF_ID_Write stall and the EX stage's branch redirect/flush.
- One 32-bit skid register absorbs a response that arrives while the pipeline is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on bubble/flush (addi x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
IF_ID_Write  input  1  1 = IF/ID may load; 0 = stall (IF/ID and PC hold)
branch_taken  input  1  redirect + flush request from EX
branch_target  input  32  redirect address
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address (= PC)
imem_ready  input  1  imem_rdata valid for the current imem_addr this cycle
imem_rdata  input  32  fetched instruction
instr  output  32  IF/ID instruction
instr_OP  output  7  instr[6:0]
Ra  output  5  instr[19:15]
Rb  output  5  instr[24:20]
Rd  output  5  instr[11:7]
pc_out  output  32  IF/ID PC of instr
pc_plus4  output  32  pc_out + 4, modulo 2^32
instr_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=FETCH, skid cleared.
  - instr=NOP_INSTR, pc_out=0, instr_valid=0.
  - imem_req is 0 while rst is high.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; skid holds a fetched word for pc.
- Priority per edge: rst > branch_taken > IF_ID_Write/handshake.
- branch_taken=1, any state:
  - pc <= {branch_target[31:2],2'b00}.
  - IF/ID <= NOP_INSTR with valid=0; pc_out unchanged.
  - Skid discarded; state <= FETCH.
  - Any same-cycle imem_ready response is dropped.
  - Overrides IF_ID_Write=0.
  - Memory treats the address change as an abort of the outstanding request.
- FETCH, imem_ready=1, IF_ID_Write=1: IF/ID <= {imem_rdata, pc, valid=1}; pc <= pc+4; stay FETCH. Back-to-back fetches give throughput of 1 instruction/cycle.
- FETCH, imem_ready=1, IF_ID_Write=0: skid <= imem_rdata; IF/ID holds; pc holds; state <= HOLD.
- FETCH, imem_ready=0, IF_ID_Write=1: IF/ID <= bubble (NOP_INSTR, valid=0); pc holds; imem_addr stable.
- FETCH, imem_ready=0, IF_ID_Write=0: everything holds.
- HOLD, IF_ID_Write=1: IF/ID <= {skid, pc, valid=1}; pc <= pc+4; state <= FETCH.
- HOLD, IF_ID_Write=0: hold.
- PC arithmetic: 32-bit wrap, 32'hFFFF_FFFC + 4 = 0; pc[1:0] is always 00.
- Field slices and pc_plus4 are combinational from IF/ID registers, with no extra latency.
- Fetch-to-decode latency: instruction visible on instr the cycle after the imem_ready edge.

Test Plan:
- Reset then imem_ready tied 1, memory word[n]=n+0x100 -> first edge after reset: imem_addr=0; next cycle instr=0x100, pc_out=0, valid=1; then pc_out 4, 8, 12 on consecutive cycles.
- imem_ready low 2 cycles at addr 8 -> imem_addr held 8; two bubbles (instr=0x13, valid=0); then instr=word[2], pc_out=8.
- IF_ID_Write=0 for 3 cycles while response for addr 12 arrives -> state HOLD, imem_req=0, IF/ID unchanged; on release, instr=word[3], pc_out=12, next imem_addr=16.
- branch_taken=1, branch_target=0x203 during HOLD with IF_ID_Write=0 -> next cycle instr=0x13, valid=0, imem_addr=0x200, skid word never appears.
- Branch to 0xFFFF_FFFC with ready=1 -> pc_out=0xFFFF_FFFC, pc_plus4=0, next imem_addr=0.
- rst asserted mid-stream in HOLD -> next cycle imem_req=0, valid=0, instr=0x13; after release, imem_addr=RESET_PC.
